// File: rtl/rgb_pulse_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pulse_decode_pkg
//  Description : Shared WS2812b timing constants (96 MHz clock) and the
//                pulse-decoder state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb_pulse_decode_pkg;

    // Default decode timing in clocks of the 96 MHz reference
    localparam int c_min_hi_clks = 16;    // shorter high pulses are glitches
    localparam int c_thresh_clks = 58;    // 0.6 us split between T0H and T1H
    localparam int c_reset_clks  = 4800;  // 50 us stable level = stream reset
    localparam int c_cnt_w       = 13;    // holds c_reset_clks

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_HIGH   = 2'd1,
        S_STABLE = 2'd2
    } state_t;

endpackage : rgb_pulse_decode_pkg
`default_nettype wire

// File: rtl/rgb_pulse_decode_sync.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pulse_decode_sync
//  Description : Two-flop synchroniser for the asynchronous data pin plus a
//                delay flop, producing single-cycle rise/fall indications.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_pulse_decode_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_din_s;
    logic r_din_q;

    // Metastability filter followed by one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_din_s <= 1'b0;
            r_din_q <= 1'b0;
        end else begin
            r_meta  <= i_din;
            r_din_s <= r_meta;
            r_din_q <= r_din_s;
        end
    end

    assign o_rise = r_din_s & ~r_din_q;
    assign o_fall = r_din_q & ~r_din_s;

endmodule : rgb_pulse_decode_sync
`default_nettype wire

// File: rtl/rgb_pulse_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pulse_decode
//  Description : WS2812b serial front end. Measures synchronised high-pulse
//                widths and emits a 2-clock strobe for each decoded bit or
//                stream reset; counts rejected glitch pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_pulse_decode
    import rgb_pulse_decode_pkg::*;
#(
    parameter int MIN_HI_CLKS = c_min_hi_clks,
    parameter int THRESH_CLKS = c_thresh_clks,
    parameter int RESET_CLKS  = c_reset_clks,
    parameter int CNT_W       = c_cnt_w
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       out_strobe,
    output logic       out_sbit_value,
    output logic       out_stream_reset,
    output logic [7:0] out_glitch_cnt
);

    localparam logic [CNT_W-1:0] c_min_hi = CNT_W'(MIN_HI_CLKS);
    localparam logic [CNT_W-1:0] c_thresh = CNT_W'(THRESH_CLKS);
    localparam logic [CNT_W-1:0] c_reset  = CNT_W'(RESET_CLKS);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_emit;
    logic             w_emit_val;
    logic             w_emit_rst;
    logic             w_glitch;
    logic             r_strobe;
    logic             r_hold;
    logic             r_val;
    logic             r_srst;
    logic [7:0]       r_glitch_cnt;

    rgb_pulse_decode_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_din  (din),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Level-duration counter; the edge cycle counts as the first clock of
    // the new level, so at a fall it equals the number of high clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rise || w_fall) begin
            r_cnt <= c_one;
        end else if (r_cnt != c_reset) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and event decode
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_val  = 1'b0;
        w_emit_rst  = 1'b0;
        w_glitch    = 1'b0;
        case (r_state)
            S_LOW: begin
                if (w_rise) begin
                    w_state_nxt = S_HIGH;
                end else if (r_cnt == c_reset) begin
                    w_emit      = 1'b1;
                    w_emit_rst  = 1'b1;
                    w_state_nxt = S_STABLE;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_state_nxt = S_LOW;
                    if (r_cnt < c_min_hi) begin
                        w_glitch = 1'b1;
                    end else begin
                        w_emit     = 1'b1;
                        w_emit_val = (r_cnt >= c_thresh);
                    end
                end else if (r_cnt == c_reset) begin
                    w_emit      = 1'b1;
                    w_emit_rst  = 1'b1;
                    w_state_nxt = S_STABLE;
                end
            end
            S_STABLE: begin
                // Reset already reported; the edge leaving this state is silent
                if (w_rise) begin
                    w_state_nxt = S_HIGH;
                end else if (w_fall) begin
                    w_state_nxt = S_LOW;
                end
            end
            default: begin
                w_state_nxt = S_LOW;
            end
        endcase
    end

    // Strobe stretcher: a new event reloads the flags and restarts the window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe <= 1'b0;
            r_hold   <= 1'b0;
            r_val    <= 1'b0;
            r_srst   <= 1'b0;
        end else if (w_emit) begin
            r_strobe <= 1'b1;
            r_hold   <= 1'b0;
            r_val    <= w_emit_val;
            r_srst   <= w_emit_rst;
        end else if (r_strobe) begin
            if (r_hold) begin
                r_strobe <= 1'b0;
                r_hold   <= 1'b0;
            end else begin
                r_hold   <= 1'b1;
            end
        end
    end

    // Saturating count of rejected short pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= 8'd0;
        end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign out_strobe       = r_strobe;
    assign out_sbit_value   = r_val;
    assign out_stream_reset = r_srst;
    assign out_glitch_cnt   = r_glitch_cnt;

endmodule : rgb_pulse_decode
`default_nettype wire

// File: tb/tb_rgb_pulse_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_pulse_decode
//  Description : Directed self-checking bench for rgb_pulse_decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_pulse_decode;

    logic       clk;
    logic       rst;
    logic       din;
    logic       out_strobe;
    logic       out_sbit_value;
    logic       out_stream_reset;
    logic [7:0] out_glitch_cnt;

    int total;
    int bad;
    int cyc;

    // Strobe log captured by the monitor
    bit ev_val [64];
    bit ev_rst [64];
    int ev_cyc [64];
    int ev_wid [64];
    int ev_n;
    int run;
    bit prev_s;

    rgb_pulse_decode dut (
        .clk              (clk),
        .rst              (rst),
        .din              (din),
        .out_strobe       (out_strobe),
        .out_sbit_value   (out_sbit_value),
        .out_stream_reset (out_stream_reset),
        .out_glitch_cnt   (out_glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe: flags and cycle at its rising sample, then width
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (out_strobe) begin
            if (!prev_s) begin
                if (ev_n < 64) begin
                    ev_val[ev_n] = out_sbit_value;
                    ev_rst[ev_n] = out_stream_reset;
                    ev_cyc[ev_n] = cyc;
                    ev_wid[ev_n] = 0;
                end
                ev_n = ev_n + 1;
                run  = 0;
            end
            run = run + 1;
            if (ev_n > 0 && ev_n <= 64) ev_wid[ev_n-1] = run;
        end else begin
            run = 0;
        end
        prev_s = out_strobe;
    end

    task automatic clear_events();
        for (int i = 0; i < 64; i++) begin
            ev_val[i] = 1'b0;
            ev_rst[i] = 1'b0;
            ev_cyc[i] = 0;
            ev_wid[i] = 0;
        end
        ev_n = 0;
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (out_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b want=0", out_strobe); end
        total++; if (out_sbit_value !== 1'b0) begin bad++; $display("FAIL rst_value got=%b want=0", out_sbit_value); end
        total++; if (out_stream_reset !== 1'b0) begin bad++; $display("FAIL rst_sreset got=%b want=0", out_stream_reset); end
        total++; if (out_glitch_cnt !== 8'd0) begin bad++; $display("FAIL rst_glitch got=%0d want=0", out_glitch_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_bit();
        int fall_first;
        clear_events();
        din = 1'b1;
        repeat (40) @(negedge clk);
        din = 1'b0;
        fall_first = cyc + 1;
        repeat (80) @(negedge clk);
        total++; if (ev_n !== 1) begin bad++; $display("FAIL t1_count got=%0d want=1", ev_n); end
        total++; if (ev_val[0] !== 1'b0) begin bad++; $display("FAIL t1_value got=%b want=0", ev_val[0]); end
        total++; if (ev_rst[0] !== 1'b0) begin bad++; $display("FAIL t1_sreset got=%b want=0", ev_rst[0]); end
        total++; if (ev_wid[0] !== 2) begin bad++; $display("FAIL t1_width got=%0d want=2", ev_wid[0]); end
        total++; if (ev_cyc[0] !== fall_first + 2) begin bad++; $display("FAIL t1_latency got=%0d want=%0d", ev_cyc[0], fall_first + 2); end
    endtask

    task automatic test_threshold();
        clear_events();
        pulse(57, 80);
        pulse(58, 80);
        pulse(77, 80);
        total++; if (ev_n !== 3) begin bad++; $display("FAIL t2_count got=%0d want=3", ev_n); end
        total++; if (ev_val[0] !== 1'b0) begin bad++; $display("FAIL t2_hi57 got=%b want=0", ev_val[0]); end
        total++; if (ev_val[1] !== 1'b1) begin bad++; $display("FAIL t2_hi58 got=%b want=1", ev_val[1]); end
        total++; if (ev_val[2] !== 1'b1) begin bad++; $display("FAIL t2_hi77 got=%b want=1", ev_val[2]); end
        total++; if (ev_wid[2] !== 2) begin bad++; $display("FAIL t2_width got=%0d want=2", ev_wid[2]); end
    endtask

    task automatic test_glitch();
        clear_events();
        pulse(10, 20);
        total++; if (out_glitch_cnt !== 8'd1) begin bad++; $display("FAIL t3_glitch1 got=%0d want=1", out_glitch_cnt); end
        for (int i = 0; i < 299; i++) pulse(10, 20);
        total++; if (out_glitch_cnt !== 8'd255) begin bad++; $display("FAIL t3_glitch_sat got=%0d want=255", out_glitch_cnt); end
        total++; if (ev_n !== 0) begin bad++; $display("FAIL t3_no_strobe got=%0d want=0", ev_n); end
    endtask

    task automatic test_low_reset();
        clear_events();
        pulse(40, 10000);
        total++; if (ev_n !== 2) begin bad++; $display("FAIL t4_count got=%0d want=2", ev_n); end
        total++; if (ev_rst[1] !== 1'b1) begin bad++; $display("FAIL t4_sreset got=%b want=1", ev_rst[1]); end
        total++; if (ev_val[1] !== 1'b0) begin bad++; $display("FAIL t4_value got=%b want=0", ev_val[1]); end
        total++; if (ev_cyc[1] - ev_cyc[0] !== 4800) begin bad++; $display("FAIL t4_delay got=%0d want=4800", ev_cyc[1] - ev_cyc[0]); end
    endtask

    task automatic test_high_reset();
        int rise_first;
        clear_events();
        din = 1'b1;
        rise_first = cyc + 1;
        repeat (5000) @(negedge clk);
        din = 1'b0;
        repeat (100) @(negedge clk);
        total++; if (ev_n !== 1) begin bad++; $display("FAIL t5_count got=%0d want=1", ev_n); end
        total++; if (ev_rst[0] !== 1'b1) begin bad++; $display("FAIL t5_sreset got=%b want=1", ev_rst[0]); end
        total++; if (ev_cyc[0] !== rise_first + 4802) begin bad++; $display("FAIL t5_delay got=%0d want=%0d", ev_cyc[0], rise_first + 4802); end
    endtask

    task automatic test_mid_reset();
        pulse(70, 40);
        clear_events();
        din = 1'b1;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (out_sbit_value !== 1'b0) begin bad++; $display("FAIL t6_rst_value got=%b want=0", out_sbit_value); end
        total++; if (out_glitch_cnt !== 8'd0) begin bad++; $display("FAIL t6_rst_glitch got=%0d want=0", out_glitch_cnt); end
        repeat (10) @(negedge clk);
        din = 1'b0;
        repeat (80) @(negedge clk);
        total++; if (ev_n !== 0) begin bad++; $display("FAIL t6_no_strobe got=%0d want=0", ev_n); end
        total++; if (out_glitch_cnt !== 8'd1) begin bad++; $display("FAIL t6_tail_glitch got=%0d want=1", out_glitch_cnt); end
    endtask

    task automatic test_frame();
        logic [23:0] frame;
        logic [23:0] word;
        int          odd;
        frame = 24'hA5C33C;
        word  = 24'd0;
        odd   = 0;
        clear_events();
        for (int i = 23; i >= 0; i--) begin
            if (frame[i]) pulse(77, 40);
            else          pulse(38, 77);
        end
        repeat (5760) @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            word = {word[22:0], ev_val[i]};
            if (ev_rst[i] !== 1'b0 || ev_wid[i] !== 2) odd++;
        end
        total++; if (ev_n !== 25) begin bad++; $display("FAIL t7_count got=%0d want=25", ev_n); end
        total++; if (word !== 24'hA5C33C) begin bad++; $display("FAIL t7_word got=%06h want=a5c33c", word); end
        total++; if (odd !== 0) begin bad++; $display("FAIL t7_bit_flags got=%0d want=0", odd); end
        total++; if (ev_rst[24] !== 1'b1 || ev_val[24] !== 1'b0) begin bad++; $display("FAIL t7_end_reset got=%b/%b want=1/0", ev_rst[24], ev_val[24]); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        ev_n   = 0;
        run    = 0;
        prev_s = 1'b0;
        rst    = 1'b1;
        din    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_bit();
        test_threshold();
        test_glitch();
        test_low_reset();
        test_high_reset();
        test_mid_reset();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rgb_pulse_decode
`default_nettype wire
